// File: rtl/dac_pkg.sv
// Shared constants, frame layout helper and FSM encoding for the LTC2624 DAC SPI writer.
package dac_pkg;

    localparam logic [3:0] CMD_WRITE         = 4'b0000;
    localparam logic [3:0] CMD_UPDATE        = 4'b0001;
    localparam logic [3:0] CMD_WRITE_UPD_ALL = 4'b0010;
    localparam logic [3:0] CMD_WRITE_UPD     = 4'b0011;
    localparam logic [3:0] CMD_PWRDN         = 4'b0100;
    localparam logic [3:0] CMD_NOP           = 4'b1111;

    localparam logic [3:0] ADDR_A   = 4'd0;
    localparam logic [3:0] ADDR_B   = 4'd1;
    localparam logic [3:0] ADDR_C   = 4'd2;
    localparam logic [3:0] ADDR_D   = 4'd3;
    localparam logic [3:0] ADDR_ALL = 4'b1111;

    localparam int FRAME_BITS = 32;
    localparam int DATA_W     = 12;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE,
        GAP
    } dac_state_t;

    // 32-bit LTC2624 word: 8 don't-care zeros, command, address, 12-bit code, 4 trailing zeros
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [3:0]        cmd,
        input logic [3:0]        addr,
        input logic [DATA_W-1:0] code
    );
        return {8'h00, cmd, addr, code, 4'h0};
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK_HALF prescaler: owns the SPI_SCK register and flags the cycles on which it rises or falls.
module spi_sck_gen #(
    parameter int SCK_HALF = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    output logic SPI_SCK,
    output logic sck_rise,
    output logic sck_fall
);

    localparam int DIV_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

    logic [DIV_W-1:0] div;
    logic             half_end;

    assign half_end = (div == DIV_W'(SCK_HALF - 1));
    assign sck_rise = en & half_end & ~SPI_SCK;
    assign sck_fall = en & half_end & SPI_SCK;

    // Disabling restarts the divider so every frame begins with a full low phase
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div     <= '0;
            SPI_SCK <= 1'b0;
        end else if (!en) begin
            div     <= '0;
            SPI_SCK <= 1'b0;
        end else if (half_end) begin
            div     <= '0;
            SPI_SCK <= ~SPI_SCK;
        end else begin
            div     <= div + 1'b1;
        end
    end

endmodule

// File: rtl/dac_spi_master.sv
// Serialises one 32-bit LTC2624 write per dactrig rising edge and pulses dacdone when CS rises.
module dac_spi_master
    import dac_pkg::*;
#(
    parameter int SCK_HALF = 2,
    parameter int CS_GAP   = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] data,
    input  logic [3:0]        address,
    input  logic [3:0]        command,
    input  logic              dactrig,
    output logic              dacdone,
    output logic              busy,
    output logic              SPI_SCK,
    output logic              SPI_MOSI,
    output logic              DAC_CS,
    output logic              DAC_CLR
);

    dac_state_t            state;
    logic                  trig_q;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] frame_in;
    logic [4:0]            bit_cnt;
    logic                  final_bit;
    logic [15:0]           cnt;
    logic                  sck_rise;
    logic                  sck_fall;

    assign frame_in = build_frame(command, address, data);

    spi_sck_gen #(
        .SCK_HALF (SCK_HALF)
    ) u_sck_gen (
        .CLK      (CLK),
        .RST      (RST),
        .en       (state == SHIFT),
        .SPI_SCK  (SPI_SCK),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    // The bit counter steps on SCK rise; MOSI only moves on SCK fall, so the
    // frame ends on the fall that follows the rise of bit 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            trig_q    <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            final_bit <= 1'b0;
            cnt       <= '0;
            dacdone   <= 1'b0;
            busy      <= 1'b0;
            SPI_MOSI  <= 1'b0;
            DAC_CS    <= 1'b1;
            DAC_CLR   <= 1'b0;
        end else begin
            trig_q  <= dactrig;
            DAC_CLR <= 1'b1;
            case (state)
                IDLE: begin
                    if (dactrig && !trig_q) begin
                        shreg     <= frame_in;
                        SPI_MOSI  <= frame_in[FRAME_BITS-1];
                        DAC_CS    <= 1'b0;
                        busy      <= 1'b1;
                        bit_cnt   <= 5'd31;
                        final_bit <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        if (bit_cnt == 5'd0) begin
                            final_bit <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end
                    if (sck_fall) begin
                        if (final_bit) begin
                            DAC_CS   <= 1'b1;
                            SPI_MOSI <= 1'b0;
                            dacdone  <= 1'b1;
                            cnt      <= '0;
                            state    <= DONE;
                        end else begin
                            shreg    <= {shreg[FRAME_BITS-2:0], 1'b0};
                            SPI_MOSI <= shreg[FRAME_BITS-2];
                        end
                    end
                end
                DONE: begin
                    if (cnt == 16'(2 * SCK_HALF - 1)) begin
                        dacdone <= 1'b0;
                        cnt     <= '0;
                        if (CS_GAP == 0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == 16'(CS_GAP - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_master.sv
// Directed bench for dac_spi_master: frames captured on SCK rises are scored against a queue of expected words.
module tb_dac_spi_master;
    import dac_pkg::*;

    localparam int GAP_CYC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] data = '0;
    logic [3:0]  address = '0;
    logic [3:0]  command = '0;
    logic        trig0 = 1'b0;
    logic        trig1 = 1'b0;
    logic        sel = 1'b0;

    logic done0, busy0, sck0, mosi0, cs0, clr0;
    logic done1, busy1, sck1, mosi1, cs1, clr1;
    logic m_done, m_busy, m_sck, m_mosi, m_cs, m_clr;
    int   half;

    int errors = 0;
    int checks = 0;
    int frames_done = 0;
    int done_rises = 0;
    logic mosi_bad = 1'b0;
    logic [31:0] expq[$];

    always #5 clk = ~clk;

    dac_spi_master #(.SCK_HALF(2), .CS_GAP(GAP_CYC)) dut_h2 (
        .CLK(clk), .RST(rst), .data(data), .address(address), .command(command),
        .dactrig(trig0), .dacdone(done0), .busy(busy0), .SPI_SCK(sck0),
        .SPI_MOSI(mosi0), .DAC_CS(cs0), .DAC_CLR(clr0)
    );

    dac_spi_master #(.SCK_HALF(1), .CS_GAP(GAP_CYC)) dut_h1 (
        .CLK(clk), .RST(rst), .data(data), .address(address), .command(command),
        .dactrig(trig1), .dacdone(done1), .busy(busy1), .SPI_SCK(sck1),
        .SPI_MOSI(mosi1), .DAC_CS(cs1), .DAC_CLR(clr1)
    );

    assign m_done = sel ? done1 : done0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_sck  = sel ? sck1  : sck0;
    assign m_mosi = sel ? mosi1 : mosi0;
    assign m_cs   = sel ? cs1   : cs0;
    assign m_clr  = sel ? clr1  : clr0;
    assign half   = sel ? 1 : 2;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic set_trig(input logic v);
        if (sel) trig1 = v;
        else trig0 = v;
    endtask

    task automatic apply_stimulus(input logic [11:0] d, input logic [3:0] a, input logic [3:0] c,
                                  input logic [31:0] expected, input bit hold);
        @(negedge clk);
        data = d;
        address = a;
        command = c;
        set_trig(1'b1);
        expq.push_back(expected);
        @(negedge clk);
        if (!hold) set_trig(1'b0);
    endtask

    task automatic pulse_trig();
        @(negedge clk);
        set_trig(1'b1);
        @(negedge clk);
        set_trig(1'b0);
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!m_busy) break;
        end
        check_output("idle_timeout", 32'(m_busy), 32'd0);
    endtask

    // Bus monitor: rebuilds each frame from MOSI at SCK rises and scores it when CS rises
    initial begin
        logic [31:0] cap, exp_f;
        int rises, cs_len, hi_run, dd_run, gap;
        logic sck_bad, have_prev, prev_cs, prev_sck, prev_done;
        cap = '0; rises = 0; cs_len = 0; hi_run = 0; dd_run = 0; gap = 0;
        sck_bad = 1'b0; have_prev = 1'b0; prev_cs = 1'b1; prev_sck = 1'b0; prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cap = '0; rises = 0; cs_len = 0; hi_run = 0; dd_run = 0;
                sck_bad = 1'b0; have_prev = 1'b0;
                prev_cs = 1'b1; prev_sck = 1'b0; prev_done = 1'b0;
            end else begin
                if (!m_cs && prev_cs) begin
                    if (have_prev) check_output("cs_gap_ok", 32'(gap >= 2 * half + GAP_CYC), 32'd1);
                    cap = '0; rises = 0; cs_len = 0; sck_bad = 1'b0;
                end
                if (m_cs) begin
                    gap++;
                    if (m_mosi) mosi_bad = 1'b1;
                end else begin
                    cs_len++;
                    if (m_sck && !prev_sck) begin
                        cap = {cap[30:0], m_mosi};
                        rises++;
                    end
                end
                if (m_sck) hi_run++;
                else if (prev_sck) begin
                    if (hi_run != half) sck_bad = 1'b1;
                    hi_run = 0;
                end
                if (m_done) dd_run++;
                else if (prev_done) begin
                    check_output("dacdone_len", dd_run, 2 * half);
                    dd_run = 0;
                end
                if (m_done && !prev_done) done_rises++;
                if (m_cs && !prev_cs) begin
                    exp_f = (expq.size() > 0) ? expq.pop_front() : 'x;
                    check_output("frame", cap, exp_f);
                    check_output("sck_rises", rises, 32);
                    check_output("cs_low_len", cs_len, 64 * half);
                    check_output("done_at_cs_rise", 32'(m_done), 32'd1);
                    check_output("sck_half_period", 32'(sck_bad), 32'd0);
                    frames_done++;
                    have_prev = 1'b1;
                    gap = 1;
                end
                prev_cs = m_cs;
                prev_sck = m_sck;
                prev_done = m_done;
            end
        end
    end

    initial begin
        int f0, d0;

        // Asynchronous reset with no clock edge needed
        #2 rst = 1'b1;
        #2;
        check_output("rst_cs", 32'(m_cs), 32'd1);
        check_output("rst_sck", 32'(m_sck), 32'd0);
        check_output("rst_mosi", 32'(m_mosi), 32'd0);
        check_output("rst_done", 32'(m_done), 32'd0);
        check_output("rst_busy", 32'(m_busy), 32'd0);
        check_output("rst_clr", 32'(m_clr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("clr_release", 32'(m_clr), 32'd1);

        $display("[TB] frame 1: data=5f3");
        apply_stimulus(12'h5f3, ADDR_A, CMD_WRITE_UPD, 32'h00305F30, 1'b0);
        check_output("cs_latency", 32'(m_cs), 32'd0);
        check_output("busy_start", 32'(m_busy), 32'd1);
        wait_idle(1000);

        $display("[TB] frame 2: data=3f5");
        apply_stimulus(12'h3f5, ADDR_A, CMD_WRITE_UPD, 32'h00303F50, 1'b0);
        wait_idle(1000);

        $display("[TB] frame 3: other address/command");
        apply_stimulus(12'hABC, ADDR_B, CMD_WRITE, 32'h0001ABC0, 1'b0);
        wait_idle(1000);

        $display("[TB] dactrig held high");
        f0 = frames_done;
        apply_stimulus(12'h123, ADDR_C, CMD_WRITE_UPD, 32'h00321230, 1'b1);
        wait_idle(1000);
        repeat (300) @(negedge clk);
        check_output("held_one_frame", frames_done, f0 + 1);
        check_output("held_busy", 32'(m_busy), 32'd0);
        trig0 = 1'b0;

        $display("[TB] second trigger at bit 10 ignored");
        f0 = frames_done;
        apply_stimulus(12'h800, ADDR_D, CMD_WRITE, 32'h00038000, 1'b0);
        repeat (84) @(negedge clk);
        pulse_trig();
        wait_idle(1000);
        repeat (200) @(negedge clk);
        check_output("ignored_trig", frames_done, f0 + 1);
        check_output("ignored_busy", 32'(m_busy), 32'd0);

        $display("[TB] inputs change mid-frame");
        apply_stimulus(12'h0F0, ADDR_ALL, CMD_WRITE_UPD_ALL, 32'h002F0F00, 1'b0);
        repeat (50) @(negedge clk);
        data = 12'hfff;
        address = ADDR_A;
        command = CMD_NOP;
        wait_idle(1000);

        $display("[TB] reset at bit 16");
        f0 = frames_done;
        d0 = done_rises;
        apply_stimulus(12'h555, ADDR_A, CMD_WRITE_UPD, 32'h00305550, 1'b0);
        repeat (62) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_output("abort_cs", 32'(m_cs), 32'd1);
        check_output("abort_sck", 32'(m_sck), 32'd0);
        check_output("abort_mosi", 32'(m_mosi), 32'd0);
        check_output("abort_clr", 32'(m_clr), 32'd0);
        check_output("abort_busy", 32'(m_busy), 32'd0);
        expq.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_output("abort_no_done", done_rises, d0);
        check_output("abort_no_frame", frames_done, f0);
        apply_stimulus(12'h7A1, ADDR_B, CMD_WRITE_UPD, 32'h00317A10, 1'b0);
        wait_idle(1000);

        $display("[TB] SCK_HALF=1 build");
        @(negedge clk);
        sel = 1'b1;
        apply_stimulus(12'hC3C, ADDR_C, CMD_PWRDN, 32'h0042C3C0, 1'b0);
        check_output("h1_cs_latency", 32'(m_cs), 32'd0);
        wait_idle(1000);
        apply_stimulus(12'h5f3, ADDR_A, CMD_WRITE_UPD, 32'h00305F30, 1'b0);
        wait_idle(1000);

        repeat (5) @(negedge clk);
        check_output("queue_drained", expq.size(), 32'd0);
        check_output("mosi_low_when_cs_high", 32'(mosi_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
